// File: rtl/chiplet_hbm_link_slice.sv
// Multi-channel HBM link slice: each channel has its own FIFO, drain/isolate FSM
// and saturating egress flit counter. Channels share nothing but clock, reset and counter clear.

module chiplet_hbm_link_slice_chan #(
    parameter int FlitWidth = 64,
    parameter int Depth     = 2,
    parameter int CntWidth  = 16,
    parameter int FillW     = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FlitWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FlitWidth-1:0] out_data,
    input  logic                 isolate_req,
    output logic                 isolate_ack,
    output logic [FillW-1:0]     fill,
    output logic [CntWidth-1:0]  flit_cnt,
    input  logic                 cnt_clear
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [1:0] ST_ACTIVE   = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_ISOLATED = 2'd2;

    logic [1:0]                      state_q, state_d;
    logic [Depth-1:0][FlitWidth-1:0] mem_q;
    logic [PtrW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [FillW-1:0]                fill_q;
    logic [CntWidth-1:0]             cnt_q;
    logic                            push, pop;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on local state, never on out_ready, so a full
    // FIFO cannot accept on the same edge it pops.
    assign in_ready    = !rst_i && (state_q == ST_ACTIVE) && !isolate_req
                         && (fill_q < FillW'(Depth));
    assign out_valid   = (fill_q != '0) && (state_q != ST_ISOLATED);
    assign out_data    = mem_q[rd_ptr_q];
    assign isolate_ack = (state_q == ST_ISOLATED);
    assign fill        = fill_q;
    assign flit_cnt    = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (isolate_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_req)        state_d = ST_ACTIVE;
                else if (fill_q == '0)   state_d = ST_ISOLATED;
            end
            ST_ISOLATED: begin
                if (!isolate_req) state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_ACTIVE;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Saturating handshake counter; clear has priority over a same-cycle pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clear) begin
            cnt_q <= '0;
        end else if (pop && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

module chiplet_hbm_link_slice #(
    parameter int NumChan   = 4,
    parameter int FlitWidth = 64,
    parameter int Depth     = 2,
    parameter int CntWidth  = 16
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NumChan-1:0]                          in_valid_i,
    output logic [NumChan-1:0]                          in_ready_o,
    input  logic [NumChan-1:0][FlitWidth-1:0]           in_data_i,
    output logic [NumChan-1:0]                          out_valid_o,
    input  logic [NumChan-1:0]                          out_ready_i,
    output logic [NumChan-1:0][FlitWidth-1:0]           out_data_o,
    input  logic [NumChan-1:0]                          isolate_req_i,
    output logic [NumChan-1:0]                          isolate_ack_o,
    output logic [NumChan-1:0][$clog2(Depth+1)-1:0]     fill_o,
    output logic [NumChan-1:0][CntWidth-1:0]            flit_cnt_o,
    input  logic                                        cnt_clear_i
);
    localparam int FillW = $clog2(Depth + 1);

    for (genvar g = 0; g < NumChan; g++) begin : g_chan
        chiplet_hbm_link_slice_chan #(
            .FlitWidth (FlitWidth),
            .Depth     (Depth),
            .CntWidth  (CntWidth),
            .FillW     (FillW)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .in_valid    (in_valid_i[g]),
            .in_ready    (in_ready_o[g]),
            .in_data     (in_data_i[g]),
            .out_valid   (out_valid_o[g]),
            .out_ready   (out_ready_i[g]),
            .out_data    (out_data_o[g]),
            .isolate_req (isolate_req_i[g]),
            .isolate_ack (isolate_ack_o[g]),
            .fill        (fill_o[g]),
            .flit_cnt    (flit_cnt_o[g]),
            .cnt_clear   (cnt_clear_i)
        );
    end

endmodule

// File: tb/tb_chiplet_hbm_link_slice.sv
// Directed bench for chiplet_hbm_link_slice: streaming, backpressure, isolation,
// drain abort, counter saturation/clear and mid-operation reset.

module tb_chiplet_hbm_link_slice;
    localparam int NumChan   = 4;
    localparam int FlitWidth = 64;
    localparam int Depth     = 2;
    localparam int CntWidth  = 4;
    localparam int FillW     = $clog2(Depth + 1);

    logic                                clk_i = 1'b0;
    logic                                rst_i;
    logic [NumChan-1:0]                  in_valid_i;
    logic [NumChan-1:0]                  in_ready_o;
    logic [NumChan-1:0][FlitWidth-1:0]   in_data_i;
    logic [NumChan-1:0]                  out_valid_o;
    logic [NumChan-1:0]                  out_ready_i;
    logic [NumChan-1:0][FlitWidth-1:0]   out_data_o;
    logic [NumChan-1:0]                  isolate_req_i;
    logic [NumChan-1:0]                  isolate_ack_o;
    logic [NumChan-1:0][FillW-1:0]       fill_o;
    logic [NumChan-1:0][CntWidth-1:0]    flit_cnt_o;
    logic                                cnt_clear_i;

    int tests = 0;
    int fails = 0;

    chiplet_hbm_link_slice #(
        .NumChan   (NumChan),
        .FlitWidth (FlitWidth),
        .Depth     (Depth),
        .CntWidth  (CntWidth)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .isolate_req_i (isolate_req_i),
        .isolate_ack_o (isolate_ack_o),
        .fill_o        (fill_o),
        .flit_cnt_o    (flit_cnt_o),
        .cnt_clear_i   (cnt_clear_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = '0; in_data_i = '0; out_ready_i = '1;
        isolate_req_i = '0; cnt_clear_i = 1'b0;
        step(); step();
        tests++; if (fill_o !== '0) begin fails++; $display("FAIL rst_fill got=%h exp=0", fill_o); end
        tests++; if (out_valid_o !== '0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid_o); end
        tests++; if (isolate_ack_o !== '0) begin fails++; $display("FAIL rst_ack got=%b exp=0000", isolate_ack_o); end
        tests++; if (in_ready_o !== '0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready_o); end
        tests++; if (flit_cnt_o !== '0) begin fails++; $display("FAIL rst_cnt got=%h exp=0", flit_cnt_o); end
        rst_i = 1'b0; #1;
        tests++; if (in_ready_o !== 4'b1111) begin fails++; $display("FAIL rst_release_in_ready got=%b exp=1111", in_ready_o); end
    endtask

    task automatic test_stream();
        out_ready_i = '1;
        for (int i = 1; i <= 8; i++) begin
            in_valid_i[0] = 1'b1; in_data_i[0] = 64'(i); #1;
            tests++; if (in_ready_o[0] !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready_o[0]); end
            step();
            tests++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== 64'(i))
                begin fails++; $display("FAIL stream_out[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid_o[0], out_data_o[0], 64'(i)); end
        end
        in_valid_i[0] = 1'b0;
        step();
        tests++; if (fill_o[0] !== 2'd0 || out_valid_o[0] !== 1'b0) begin fails++; $display("FAIL stream_empty got fill=%0d v=%b exp 0 0", fill_o[0], out_valid_o[0]); end
        tests++; if (flit_cnt_o[0] !== 4'd8) begin fails++; $display("FAIL stream_cnt got=%0d exp=8", flit_cnt_o[0]); end
    endtask

    task automatic test_backpressure();
        out_ready_i[1] = 1'b0;
        in_valid_i[1] = 1'b1; in_data_i[1] = 64'hA1; #1;
        tests++; if (in_ready_o[1] !== 1'b1) begin fails++; $display("FAIL bp_rdy0 got=%b exp=1", in_ready_o[1]); end
        step();
        in_data_i[1] = 64'hA2; #1;
        tests++; if (in_ready_o[1] !== 1'b1) begin fails++; $display("FAIL bp_rdy1 got=%b exp=1", in_ready_o[1]); end
        step();
        in_data_i[1] = 64'hA3; #1;
        tests++; if (in_ready_o[1] !== 1'b0) begin fails++; $display("FAIL bp_rdy_full got=%b exp=0", in_ready_o[1]); end
        tests++; if (fill_o[1] !== 2'd2) begin fails++; $display("FAIL bp_fill_full got=%0d exp=2", fill_o[1]); end
        step();
        in_valid_i[1] = 1'b0; #1;
        tests++; if (fill_o[1] !== 2'd2 || out_data_o[1] !== 64'hA1) begin fails++; $display("FAIL bp_hold got fill=%0d d=%h exp 2 a1", fill_o[1], out_data_o[1]); end
        out_ready_i[1] = 1'b1;
        step();
        tests++; if (fill_o[1] !== 2'd1 || out_data_o[1] !== 64'hA2) begin fails++; $display("FAIL bp_pop1 got fill=%0d d=%h exp 1 a2", fill_o[1], out_data_o[1]); end
        step();
        tests++; if (fill_o[1] !== 2'd0 || out_valid_o[1] !== 1'b0) begin fails++; $display("FAIL bp_drained got fill=%0d v=%b exp 0 0", fill_o[1], out_valid_o[1]); end
        tests++; if (flit_cnt_o[1] !== 4'd2) begin fails++; $display("FAIL bp_cnt got=%0d exp=2", flit_cnt_o[1]); end
    endtask

    task automatic test_isolation();
        out_ready_i[2] = 1'b0;
        in_valid_i[2] = 1'b1; in_data_i[2] = 64'hB1; step();
        in_data_i[2] = 64'hB2; step();
        in_valid_i[2] = 1'b0;
        isolate_req_i[2] = 1'b1; out_ready_i[2] = 1'b1; #1;
        tests++; if (in_ready_o[2] !== 1'b0) begin fails++; $display("FAIL iso_rdy_drop got=%b exp=0", in_ready_o[2]); end
        tests++; if (out_data_o[2] !== 64'hB1) begin fails++; $display("FAIL iso_head got=%h exp=b1", out_data_o[2]); end
        step();
        tests++; if (isolate_ack_o[2] !== 1'b0 || out_data_o[2] !== 64'hB2) begin fails++; $display("FAIL iso_drain1 got ack=%b d=%h exp 0 b2", isolate_ack_o[2], out_data_o[2]); end
        step();
        tests++; if (isolate_ack_o[2] !== 1'b0 || out_valid_o[2] !== 1'b0) begin fails++; $display("FAIL iso_drain2 got ack=%b v=%b exp 0 0", isolate_ack_o[2], out_valid_o[2]); end
        step();
        tests++; if (isolate_ack_o[2] !== 1'b1 || in_ready_o[2] !== 1'b0 || out_valid_o[2] !== 1'b0)
            begin fails++; $display("FAIL iso_ack got ack=%b rdy=%b v=%b exp 1 0 0", isolate_ack_o[2], in_ready_o[2], out_valid_o[2]); end
        isolate_req_i[2] = 1'b0;
        step();
        tests++; if (isolate_ack_o[2] !== 1'b0 || in_ready_o[2] !== 1'b1) begin fails++; $display("FAIL iso_release got ack=%b rdy=%b exp 0 1", isolate_ack_o[2], in_ready_o[2]); end
        tests++; if (flit_cnt_o[2] !== 4'd2) begin fails++; $display("FAIL iso_cnt got=%0d exp=2", flit_cnt_o[2]); end
    endtask

    task automatic test_abort();
        out_ready_i[3] = 1'b0;
        in_valid_i[3] = 1'b1; in_data_i[3] = 64'hC1; step();
        in_valid_i[3] = 1'b0;
        isolate_req_i[3] = 1'b1;
        step();
        tests++; if (in_ready_o[3] !== 1'b0 || isolate_ack_o[3] !== 1'b0 || fill_o[3] !== 2'd1)
            begin fails++; $display("FAIL abort_drain got rdy=%b ack=%b fill=%0d exp 0 0 1", in_ready_o[3], isolate_ack_o[3], fill_o[3]); end
        step();
        tests++; if (isolate_ack_o[3] !== 1'b0) begin fails++; $display("FAIL abort_no_ack got=%b exp=0", isolate_ack_o[3]); end
        isolate_req_i[3] = 1'b0; #1;
        tests++; if (in_ready_o[3] !== 1'b0) begin fails++; $display("FAIL abort_still_drain got rdy=%b exp=0", in_ready_o[3]); end
        step();
        tests++; if (isolate_ack_o[3] !== 1'b0 || in_ready_o[3] !== 1'b1 || fill_o[3] !== 2'd1 || out_data_o[3] !== 64'hC1)
            begin fails++; $display("FAIL abort_active got ack=%b rdy=%b fill=%0d d=%h exp 0 1 1 c1", isolate_ack_o[3], in_ready_o[3], fill_o[3], out_data_o[3]); end
        out_ready_i[3] = 1'b1;
        step();
        tests++; if (fill_o[3] !== 2'd0 || flit_cnt_o[3] !== 4'd1) begin fails++; $display("FAIL abort_pop got fill=%0d cnt=%0d exp 0 1", fill_o[3], flit_cnt_o[3]); end
    endtask

    task automatic test_saturation();
        cnt_clear_i = 1'b1; step(); cnt_clear_i = 1'b0;
        tests++; if (flit_cnt_o !== '0) begin fails++; $display("FAIL sat_clear_all got=%h exp=0", flit_cnt_o); end
        out_ready_i = '1;
        for (int i = 0; i < 20; i++) begin
            in_valid_i[0] = 1'b1; in_data_i[0] = 64'(100 + i); step();
        end
        in_valid_i[0] = 1'b0; step();
        tests++; if (flit_cnt_o[0] !== 4'd15) begin fails++; $display("FAIL sat_cnt got=%0d exp=15", flit_cnt_o[0]); end
        in_valid_i[0] = 1'b1; in_data_i[0] = 64'hD0; step();
        in_valid_i[0] = 1'b0; #1;
        tests++; if (out_valid_o[0] !== 1'b1 || flit_cnt_o[0] !== 4'd15) begin fails++; $display("FAIL sat_hold got v=%b cnt=%0d exp 1 15", out_valid_o[0], flit_cnt_o[0]); end
        cnt_clear_i = 1'b1; step(); cnt_clear_i = 1'b0;
        tests++; if (flit_cnt_o[0] !== 4'd0 || fill_o[0] !== 2'd0) begin fails++; $display("FAIL sat_clear_wins got cnt=%0d fill=%0d exp 0 0", flit_cnt_o[0], fill_o[0]); end
    endtask

    task automatic test_reset_mid();
        out_ready_i = '0; in_valid_i = '1;
        for (int c = 0; c < NumChan; c++) in_data_i[c] = 64'hF00 + 64'(c);
        step(); step();
        in_valid_i = '0; #1;
        tests++; if (fill_o !== {NumChan{2'd2}} || in_ready_o !== '0) begin fails++; $display("FAIL mid_full got fill=%h rdy=%b exp aa 0000", fill_o, in_ready_o); end
        rst_i = 1'b1; step();
        tests++; if (fill_o !== '0 || out_valid_o !== '0 || in_ready_o !== '0) begin fails++; $display("FAIL mid_rst got fill=%h v=%b rdy=%b exp 0", fill_o, out_valid_o, in_ready_o); end
        rst_i = 1'b0; out_ready_i = '1; #1;
        tests++; if (in_ready_o !== 4'b1111) begin fails++; $display("FAIL mid_rdy got=%b exp=1111", in_ready_o); end
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (out_valid_o !== '0 || flit_cnt_o !== '0) begin fails++; $display("FAIL mid_ghost[%0d] got v=%b cnt=%h exp 0", i, out_valid_o, flit_cnt_o); end
        end
        in_valid_i[0] = 1'b1; in_data_i[0] = 64'hE1; step();
        in_valid_i[0] = 1'b0; #1;
        tests++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== 64'hE1) begin fails++; $display("FAIL mid_fresh got v=%b d=%h exp 1 e1", out_valid_o[0], out_data_o[0]); end
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_isolation();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
